// File: rtl/timer_core.sv
`default_nettype none
// ============================================================================
// Module   : timer_core
// Brief    : Prescaled 32-bit down-counter with start/stop, sticky and pulsed
//            expiry flags and optional auto-reload.
// Revision : 1.0  initial release
// ============================================================================
module timer_core #(
  parameter int unsigned PRESCALE    = 0,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] load_value,
  input  logic        start,
  input  logic        stop,
  output logic        expired,
  output logic        expired_pulse,
  output logic        running,
  output logic [31:0] count_value
);

  localparam logic [15:0] C_PRESCALE = 16'(PRESCALE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_presc;
  logic [15:0] w_presc_nxt;
  logic [31:0] r_count;
  logic [31:0] w_count_nxt;
  logic        r_expired;
  logic        w_expired_nxt;
  logic        r_pulse;
  logic        w_pulse_nxt;
  logic        w_tick;

  assign w_tick = (r_state == RUN) && (r_presc == C_PRESCALE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_count   <= '0;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_count   <= w_count_nxt;
      r_expired <= w_expired_nxt;
      r_pulse   <= w_pulse_nxt;
    end
  end

  // Priority: stop, then start, then the running countdown.
  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_count_nxt   = r_count;
    w_expired_nxt = r_expired;
    w_pulse_nxt   = 1'b0;
    if (stop) begin
      w_state_nxt   = IDLE;
      w_expired_nxt = 1'b0;
      w_presc_nxt   = '0;
    end else if (start) begin
      w_presc_nxt = '0;
      if (load_value == 32'd0) begin
        w_state_nxt   = EXPIRED;
        w_count_nxt   = '0;
        w_expired_nxt = 1'b1;
        w_pulse_nxt   = 1'b1;
      end else begin
        w_state_nxt   = RUN;
        w_count_nxt   = load_value;
        w_expired_nxt = 1'b0;
      end
    end else if (r_state == RUN) begin
      w_presc_nxt = w_tick ? 16'd0 : r_presc + 16'd1;
      if (w_tick) begin
        if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // Count of 1 on a tick is the expiry event.
          w_expired_nxt = 1'b1;
          w_pulse_nxt   = 1'b1;
          if (AUTO_RELOAD && (load_value != 32'd0)) begin
            w_count_nxt = load_value;
          end else begin
            w_count_nxt = '0;
            w_state_nxt = EXPIRED;
          end
        end
      end
    end
  end

  assign expired       = r_expired;
  assign expired_pulse = r_pulse;
  assign running       = (r_state == RUN);
  assign count_value   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_core
// Brief    : Scoreboard bench for timer_core across three parameter sets.
// Revision : 1.0  initial release
// ============================================================================
module tb_timer_core;

  typedef struct {
    int          cyc;
    int          dut;
    logic [31:0] cnt;
    logic        ex;
    logic        ep;
    logic        rn;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st [3];
  logic        sp [3];
  logic [31:0] ld [3];
  logic        ex [3];
  logic        ep [3];
  logic        rn [3];
  logic [31:0] cv [3];

  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: plain, dut1: prescaled by 4, dut2: auto-reload
  timer_core #(.PRESCALE(0), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .load_value(ld[0]), .start(st[0]), .stop(sp[0]),
    .expired(ex[0]), .expired_pulse(ep[0]), .running(rn[0]), .count_value(cv[0]));
  timer_core #(.PRESCALE(3), .AUTO_RELOAD(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .load_value(ld[1]), .start(st[1]), .stop(sp[1]),
    .expired(ex[1]), .expired_pulse(ep[1]), .running(rn[1]), .count_value(cv[1]));
  timer_core #(.PRESCALE(0), .AUTO_RELOAD(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .load_value(ld[2]), .start(st[2]), .stop(sp[2]),
    .expired(ex[2]), .expired_pulse(ep[2]), .running(rn[2]), .count_value(cv[2]));

  task automatic compare(input string n, input int d, input logic [31:0] c,
                         input logic e, input logic p, input logic r);
    vectors++;
    if (cv[d] !== c || ex[d] !== e || ep[d] !== p || rn[d] !== r) begin
      fails++;
      $display("FAIL %s dut%0d @cyc %0d: got cnt=%0d exp=%b pulse=%b run=%b, want cnt=%0d exp=%b pulse=%b run=%b",
               n, d, cyc, cv[d], ex[d], ep[d], rn[d], c, e, p, r);
    end
  endtask

  task automatic push(input string n, input int d, input int c, input logic [31:0] cnt,
                      input logic e, input logic p, input logic r);
    exp_t x;
    int   i;
    x.cyc = c; x.dut = d; x.cnt = cnt; x.ex = e; x.ep = p; x.rn = r; x.name = n;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, x);
  endtask

  // Monitor: pops every expectation that is due at this sampling point.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      if (q[0].cyc < cyc) begin
        vectors++;
        fails++;
        $display("FAIL %s: check for cyc %0d missed, now cyc %0d", q[0].name, q[0].cyc, cyc);
      end else begin
        compare(q[0].name, q[0].dut, q[0].cnt, q[0].ex, q[0].ep, q[0].rn);
      end
      void'(q.pop_front());
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive start/stop so they are sampled exactly at rising edge number x.
  task automatic drive(input int d, input int x, input logic s, input logic p,
                       input logic [31:0] v);
    goto(x - 1);
    ld[d] = v; st[d] = s; sp[d] = p;
    goto(x);
    st[d] = 1'b0; sp[d] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      vectors++;
      fails++;
      $display("FAIL drain: %0d checks still pending, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int x, s, r, z, w, f, g;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; sp[i] = 1'b0; ld[i] = '0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) push("reset", i, cyc + 1, 0, 0, 0, 0);
    goto(cyc + 1);
    reset = 1'b0;

    // Basic countdown 5..0, then stop clears sticky expired
    x = cyc + 2;
    for (int k = 0; k < 5; k++) push("basic", 0, x + k, 32'(5 - k), 0, 0, 1);
    push("basic_exp", 0, x + 5, 0, 1, 1, 0);
    push("basic_hold", 0, x + 6, 0, 1, 0, 0);
    push("stop_clr", 0, x + 8, 0, 0, 0, 0);
    drive(0, x, 1, 0, 5);
    drive(0, x + 8, 0, 1, 5);
    drain();

    // Prescale 3, load 2: steps every 4 clocks, expiry 8 clocks after start
    x = cyc + 2;
    push("presc", 1, x, 2, 0, 0, 1);
    push("presc", 1, x + 3, 2, 0, 0, 1);
    push("presc", 1, x + 4, 1, 0, 0, 1);
    push("presc", 1, x + 7, 1, 0, 0, 1);
    push("presc_exp", 1, x + 8, 0, 1, 1, 0);
    push("presc_hold", 1, x + 9, 0, 1, 0, 0);
    drive(1, x, 1, 0, 2);
    drain();

    // Stop after 4 ticks, load change mid-run ignored, restart with 3
    x = cyc + 2;
    s = x + 5;
    push("stop_run", 0, x, 10, 0, 0, 1);
    push("stop_run", 0, x + 4, 6, 0, 0, 1);
    push("stop_idle", 0, s, 6, 0, 0, 0);
    push("stop_idle", 0, s + 1, 6, 0, 0, 0);
    drive(0, x, 1, 0, 10);
    goto(x + 1);
    ld[0] = 99;
    drive(0, s, 0, 1, 99);
    r = s + 3;
    push("restart", 0, r, 3, 0, 0, 1);
    push("restart", 0, r + 2, 1, 0, 0, 1);
    push("restart_exp", 0, r + 3, 0, 1, 1, 0);
    drive(0, r, 1, 0, 3);
    drain();

    // Zero load, restart while running, simultaneous start+stop
    z = cyc + 2;
    w = z + 3;
    push("zero_load", 0, z, 0, 1, 1, 0);
    push("zero_hold", 0, z + 1, 0, 1, 0, 0);
    push("rerun", 0, w, 8, 0, 0, 1);
    push("rerun_new", 0, w + 2, 3, 0, 0, 1);
    push("rerun_new", 0, w + 4, 1, 0, 0, 1);
    push("start_stop", 0, w + 5, 1, 0, 0, 0);
    push("start_stop", 0, w + 6, 1, 0, 0, 0);
    drive(0, z, 1, 0, 0);
    drive(0, w, 1, 0, 8);
    drive(0, w + 2, 1, 0, 3);
    drive(0, w + 5, 1, 1, 20);
    drain();

    // Auto-reload every 4 clocks, stop clears sticky expired
    x = cyc + 2;
    push("auto", 2, x, 4, 0, 0, 1);
    push("auto_exp", 2, x + 4, 4, 1, 1, 1);
    push("auto_run", 2, x + 5, 3, 1, 0, 1);
    push("auto_exp", 2, x + 8, 4, 1, 1, 1);
    push("auto_run", 2, x + 9, 3, 1, 0, 1);
    push("auto_stop", 2, x + 10, 3, 0, 0, 0);
    drive(2, x, 1, 0, 4);
    drive(2, x + 10, 0, 1, 4);
    // Auto-reload that finds load_value==0 ends in EXPIRED
    f = cyc + 2;
    push("auto_zero", 2, f, 2, 0, 0, 1);
    push("auto_zero", 2, f + 1, 1, 0, 0, 1);
    push("auto_zero_exp", 2, f + 2, 0, 1, 1, 0);
    push("auto_zero_hold", 2, f + 3, 0, 1, 0, 0);
    drive(2, f, 1, 0, 2);
    ld[2] = 0;
    drain();

    // Asynchronous reset mid-count at count 7
    g = cyc + 2;
    push("pre_rst", 0, g, 9, 0, 0, 1);
    push("pre_rst", 0, g + 2, 7, 0, 0, 1);
    drive(0, g, 1, 0, 9);
    goto(g + 2);
    #2 reset = 1'b1;
    #1;
    compare("async_rst", 0, 0, 0, 0, 0);
    compare("async_rst", 2, 0, 0, 0, 0);
    push("rst_hold", 0, g + 3, 0, 0, 0, 0);
    goto(g + 3);
    reset = 1'b0;
    push("post_rst", 0, g + 4, 0, 0, 0, 0);
    push("post_rst", 0, g + 5, 0, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
